// File: rtl/alu_pkg.sv
// Shared ALU select codes, sequencer state encoding and helpers.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [2:0] sel);
        return (sel == ALU_SHL) || (sel == ALU_SHR);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: ptr picks the winner only when both request.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            unique case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one external 8-bit ALU between two requesters; multi-bit shifts are
// built by feeding the ALU's 1-bit shift result back into operand A each cycle.
module alu_sched
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_sel,
    input  logic [CNT_W-1:0]  req0_shamt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_sel,
    input  logic [CNT_W-1:0]  req1_shamt,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_zero,
    output logic              busy,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero
);

    state_e            state_q;
    logic              rr_ptr_q;
    logic              owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [2:0]        alu_sel_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              resp_zero_q;

    logic [1:0]        grant;
    logic [DATA_W-1:0] pick_a;
    logic [DATA_W-1:0] pick_b;
    logic [2:0]        pick_sel;
    logic [CNT_W-1:0]  pick_shamt;

    // Readies are held low during reset even though the state already reads idle.
    rr_arb2 u_arb (
        .valid_i  ({req1_valid, req0_valid}),
        .ptr_i    (rr_ptr_q),
        .enable_i ((state_q == StIdle) && !reset),
        .grant_o  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        pick_a     = req0_a;
        pick_b     = req0_b;
        pick_sel   = req0_sel;
        pick_shamt = req0_shamt;
        if (grant[1]) begin
            pick_a     = req1_a;
            pick_b     = req1_b;
            pick_sel   = req1_sel;
            pick_shamt = req1_shamt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= 1'b0;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= ALU_ADD;
            resp_data_q <= '0;
            resp_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|grant) begin
                        owner_q   <= grant[1];
                        rr_ptr_q  <= ~grant[1];
                        alu_a_q   <= pick_a;
                        alu_b_q   <= pick_b;
                        alu_sel_q <= pick_sel;
                        cnt_q     <= pick_shamt;
                        // A zero-length shift is the operand itself; skip the ALU.
                        if (is_shift(pick_sel) && (pick_shamt == '0)) begin
                            resp_data_q <= pick_a;
                            resp_zero_q <= (pick_a == '0);
                            state_q     <= StResp;
                        end else begin
                            state_q <= StExec;
                        end
                    end
                end
                StExec: begin
                    if (is_shift(alu_sel_q) && (cnt_q > CNT_W'(1))) begin
                        alu_a_q <= alu_out;
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end else begin
                        resp_data_q <= alu_out;
                        resp_zero_q <= alu_zero;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign resp0_valid = (state_q == StResp) && !owner_q;
    assign resp1_valid = (state_q == StResp) && owner_q;
    assign resp_data   = resp_data_q;
    assign resp_zero   = resp_zero_q;
    assign busy        = (state_q != StIdle);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural model of the external ALU.
module tb_alu_sched;
    import alu_pkg::*;

    logic       clk;
    logic       reset;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req1_sel, req0_shamt, req1_shamt;
    logic       resp0_valid, resp1_valid, resp_zero, busy, alu_zero;
    logic [7:0] resp_data, alu_a, alu_b, alu_out;
    logic [2:0] alu_sel;

    int n_vec  = 0;
    int n_miss = 0;

    alu_sched dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_sel    (req0_sel),
        .req0_shamt  (req0_shamt),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_sel    (req1_sel),
        .req1_shamt  (req1_shamt),
        .resp0_valid (resp0_valid),
        .resp1_valid (resp1_valid),
        .resp_data   (resp_data),
        .resp_zero   (resp_zero),
        .busy        (busy),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero)
    );

    // External ALU as it sits at CPU top level.
    always_comb begin
        alu_out = 8'h00;
        case (alu_sel)
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_SUB: alu_out = alu_a - alu_b;
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_OR:  alu_out = alu_a | alu_b;
            ALU_XOR: alu_out = alu_a ^ alu_b;
            ALU_SHL: alu_out = {alu_a[6:0], 1'b0};
            ALU_SHR: alu_out = {1'b0, alu_a[7:1]};
            default: alu_out = (alu_a < alu_b) ? 8'h01 : 8'h00;
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [2:0] sel,
                           input logic [7:0] a, input logic [7:0] b, input logic [2:0] sh);
        if (r == 0) begin
            req0_valid = v; req0_sel = sel; req0_a = a; req0_b = b; req0_shamt = sh;
        end else begin
            req1_valid = v; req1_sel = sel; req1_a = a; req1_b = b; req1_shamt = sh;
        end
    endtask

    // Issues one op, returns latency (handshake cycle = 0), result, and a count of
    // protocol violations (stray pulse to the other requester, pulse > 1 cycle, busy after).
    task automatic run_op(input int r, input logic [2:0] sel, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] sh, output int lat,
                          output logic [7:0] data, output logic z, output int wrong);
        logic ok;
        logic own;
        ok = 1'b0; lat = -1; data = 8'h00; z = 1'b0; wrong = 0;
        @(negedge clk);
        set_req(r, 1'b1, sel, a, b, sh);
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((r == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ready_seen", ok, 1);
        if (!ok) begin
            set_req(r, 1'b0, sel, a, b, sh);
            return;
        end
        @(posedge clk);
        #1;
        set_req(r, 1'b0, sel, a, b, sh);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            own = (r == 0) ? resp0_valid : resp1_valid;
            if ((r == 0) ? resp1_valid : resp0_valid) wrong++;
            if (own) begin
                lat = i; data = resp_data; z = resp_zero;
                break;
            end
        end
        @(negedge clk);
        if (resp0_valid || resp1_valid || busy) wrong++;
    endtask

    typedef struct {
        int         r;
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sh;
        logic [7:0] exp_d;
        logic       exp_z;
        int         exp_lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int         lat, wrong, k;
        logic [7:0] data;
        logic       z;
        int unsigned exp_g[4];
        int         pulses;

        vecs[0]  = '{0, ALU_ADD, 8'h05, 8'h03, 3'd0, 8'h08, 1'b0, 2};
        vecs[1]  = '{1, ALU_SUB, 8'h07, 8'h07, 3'd0, 8'h00, 1'b1, 2};
        vecs[2]  = '{0, ALU_SHL, 8'h01, 8'h00, 3'd5, 8'h20, 1'b0, 6};
        vecs[3]  = '{1, ALU_SHR, 8'h80, 8'h00, 3'd7, 8'h01, 1'b0, 8};
        vecs[4]  = '{0, ALU_SHL, 8'h00, 8'h00, 3'd0, 8'h00, 1'b1, 1};
        vecs[5]  = '{1, ALU_SLT, 8'h03, 8'h09, 3'd0, 8'h01, 1'b0, 2};
        vecs[6]  = '{0, ALU_AND, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 2};
        vecs[7]  = '{1, ALU_OR,  8'hF0, 8'h0F, 3'd0, 8'hFF, 1'b0, 2};
        vecs[8]  = '{0, ALU_XOR, 8'hAA, 8'hAA, 3'd0, 8'h00, 1'b1, 2};
        vecs[9]  = '{1, ALU_SHR, 8'h5A, 8'h00, 3'd0, 8'h5A, 1'b0, 1};
        vecs[10] = '{0, ALU_SHL, 8'h81, 8'h00, 3'd1, 8'h02, 1'b0, 2};
        vecs[11] = '{1, ALU_SLT, 8'h09, 8'h03, 3'd0, 8'h00, 1'b1, 2};
        vecs[12] = '{0, ALU_ADD, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 2};
        vecs[13] = '{1, ALU_ADD, 8'h10, 8'h20, 3'd7, 8'h30, 1'b0, 2};
        exp_g = '{0, 1, 0, 1};

        // Reset with both requesters already asking.
        reset = 1'b1;
        set_req(0, 1'b1, ALU_ADD, 8'h11, 8'h22, 3'd0);
        set_req(1, 1'b1, ALU_ADD, 8'h33, 8'h44, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", {resp1_valid, resp0_valid}, 0);
        check("rst_alu_regs", {alu_a, alu_b, 5'd0, alu_sel}, 0);
        check("rst_resp", {resp_data, 7'd0, resp_zero}, 0);
        reset = 1'b0;

        // Both held valid: grants must alternate starting with requester 0.
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            #1;
            if (req0_ready && req1_ready) check("one_hot_ready", 2, 1);
            if (req0_ready || req1_ready) begin
                check("grant_order", req1_ready ? 1 : 0, exp_g[k]);
                k++;
            end
            if (k < 4) @(negedge clk);
        end
        check("grant_count", k, 4);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Multi-bit shift: operand A must walk through the ALU one bit per cycle.
        set_req(0, 1'b1, ALU_SHL, 8'h01, 8'h00, 3'd5);
        #1;
        check("shl_ready", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("shl_alu_a", alu_a, 32'h1 << i);
            check("shl_busy_noresp", {busy, resp0_valid}, 2'b10);
        end
        @(negedge clk);
        check("shl_resp", {resp0_valid, resp_data}, {1'b1, 8'h20});

        foreach (vecs[i]) begin
            run_op(vecs[i].r, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sh, lat, data, z,
                   wrong);
            check($sformatf("vec%0d_data", i), data, vecs[i].exp_d);
            check($sformatf("vec%0d_zero", i), z, vecs[i].exp_z);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_protocol", i), wrong, 0);
        end

        // Reset in cycle 3 of a 7-step shift by requester 0 (leaves rr_ptr at 1).
        @(negedge clk);
        set_req(0, 1'b1, ALU_SHL, 8'h01, 8'h00, 3'd7);
        #1;
        check("abort_ready", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_alu_a", alu_a, 0);
        check("abort_resp_valid", {resp1_valid, resp0_valid}, 0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid || busy) pulses++;
        end
        check("abort_no_resp", pulses, 0);

        // rr_ptr back to 0: with both valid requester 0 must win.
        set_req(0, 1'b1, ALU_SUB, 8'h09, 8'h04, 3'd0);
        set_req(1, 1'b1, ALU_XOR, 8'h0F, 8'hF0, 3'd0);
        #1;
        check("post_rst_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (resp0_valid) begin
                lat = i;
                data = resp_data;
                break;
            end
        end
        check("post_rst_latency", lat, 2);
        check("post_rst_data", data, 8'h05);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
